// File: rtl/keypad_entry_n.sv
// ---------------------------------------------------------------------------
// keypad_entry_n
//
// Keypad number-entry block. Synchronises the 20 raw push-buttons, turns a
// rising edge of "any key down" into a single press event, and uses the
// highest pressed key index to build a right-justified multi-digit number.
// Supports backspace, clear and enter. Enter hands the finished number to a
// consumer over a valid/ready handshake.
//
// Parameters
//   DIGITS     number of 4-bit digits held (1..8), W = 4*DIGITS
//   RADIX_MAX  largest accepted digit key (9 = decimal, 15 = hex)
//   BKSP_KEY   key index for backspace
//   CLR_KEY    key index for clear
//   ENT_KEY    key index for enter
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-low
//   pb         raw push-buttons, asynchronous to clk
//   entry      digits entered so far, least-significant digit in [3:0]
//   count      number of significant digits in entry
//   digit_en   display enables, bit i set when i < count, bit 0 always set
//   full       count == DIGITS
//   out_data   value delivered on enter
//   out_valid  out_data is pending
//   out_ready  consumer accepts out_data
//   drop       one-cycle pulse when an enter was discarded
// ---------------------------------------------------------------------------
module keypad_entry_n #(
  parameter int DIGITS    = 8,
  parameter int RADIX_MAX = 15,
  parameter int BKSP_KEY  = 16,
  parameter int CLR_KEY   = 17,
  parameter int ENT_KEY   = 19
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [19:0]                  pb,
  output logic [4*DIGITS-1:0]          entry,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic [DIGITS-1:0]            digit_en,
  output logic                         full,
  output logic [4*DIGITS-1:0]          out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         drop
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  localparam logic [4:0]    RADIX_K    = 5'(RADIX_MAX);
  localparam logic [4:0]    BKSP_K     = 5'(BKSP_KEY);
  localparam logic [4:0]    CLR_K      = 5'(CLR_KEY);
  localparam logic [4:0]    ENT_K      = 5'(ENT_KEY);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DIGITS);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    KEY_NONE,
    KEY_DIGIT,
    KEY_BKSP,
    KEY_CLR,
    KEY_ENT
  } key_kind_e;

  logic [19:0]   pb_meta;
  logic [19:0]   pbs;
  logic          any_d;
  logic          press;
  logic [4:0]    key_code;
  key_kind_e     key_kind;

  logic [W-1:0]  entry_nxt;
  logic [CW-1:0] count_nxt;
  logic [W-1:0]  out_data_nxt;
  logic          out_valid_nxt;
  logic          drop_nxt;

  // Two-flop synchroniser plus the previous-cycle any-key flag used for
  // edge detection. Everything downstream only sees pbs, never pb.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pb_meta <= '0;
      pbs     <= '0;
      any_d   <= 1'b0;
    end else begin
      pb_meta <= pb;
      pbs     <= pb_meta;
      any_d   <= |pbs;
    end
  end

  // A press is the rising edge of "any key down", so adding a second key
  // while one is held does nothing.
  assign press = (|pbs) & ~any_d;

  // Highest set index wins when several keys are down together.
  always_comb begin
    key_code = '0;
    for (int i = 0; i < 20; i++) begin
      if (pbs[i]) key_code = 5'(i);
    end
  end

  // Classify the key. Digit range is checked first; unmapped indices such
  // as 18 fall through to KEY_NONE and are ignored.
  always_comb begin
    key_kind = KEY_NONE;
    if (key_code <= RADIX_K)    key_kind = KEY_DIGIT;
    else if (key_code == BKSP_K) key_kind = KEY_BKSP;
    else if (key_code == CLR_K)  key_kind = KEY_CLR;
    else if (key_code == ENT_K)  key_kind = KEY_ENT;
  end

  assign full = (count == COUNT_FULL);

  always_comb begin
    digit_en = '0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_en[i] = (CW'(i) < count);
    end
    digit_en[0] = 1'b1;
  end

  // Next-state logic. A completed handshake drops out_valid by default; an
  // enter in the same cycle reloads it, so out_valid then stays high.
  always_comb begin
    entry_nxt     = entry;
    count_nxt     = count;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    drop_nxt      = 1'b0;

    if (out_valid && out_ready) out_valid_nxt = 1'b0;

    if (press) begin
      unique case (key_kind)
        KEY_DIGIT: begin
          // Leading zeros are suppressed, and a full entry ignores digits.
          if (!((count == '0) && (key_code == '0)) && !full) begin
            entry_nxt = (entry << 4) | W'(key_code[3:0]);
            count_nxt = count + COUNT_ONE;
          end
        end
        KEY_BKSP: begin
          if (count != '0) begin
            entry_nxt = entry >> 4;
            count_nxt = count - COUNT_ONE;
          end
        end
        KEY_CLR: begin
          entry_nxt = '0;
          count_nxt = '0;
        end
        KEY_ENT: begin
          if (!out_valid || out_ready) begin
            out_data_nxt  = entry;
            out_valid_nxt = 1'b1;
            entry_nxt     = '0;
            count_nxt     = '0;
          end else begin
            drop_nxt = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Entry and output registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry     <= '0;
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      drop      <= 1'b0;
    end else begin
      entry     <= entry_nxt;
      count     <= count_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      drop      <= drop_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_entry_n.sv
// ---------------------------------------------------------------------------
// tb_keypad_entry_n
//
// Bench for keypad_entry_n. Two instances share the push-buttons, reset and
// out_ready: an 8-digit hex one (defaults) and a 4-digit decimal one. The
// hex instance is tracked by a small behavioural model whose expectations
// go into a scoreboard queue when a key is driven and are popped once the
// press has had time to propagate.
// ---------------------------------------------------------------------------
module tb_keypad_entry_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] pb;
  logic        out_ready;

  logic [31:0] e8_entry;
  logic [3:0]  e8_count;
  logic [7:0]  e8_digit_en;
  logic        e8_full;
  logic [31:0] e8_out_data;
  logic        e8_out_valid;
  logic        e8_drop;

  logic [15:0] e4_entry;
  logic [2:0]  e4_count;
  logic [3:0]  e4_digit_en;
  logic        e4_full;
  logic [15:0] e4_out_data;
  logic        e4_out_valid;
  logic        e4_drop;

  int assert_count = 0;
  int fail_count   = 0;

  typedef struct {
    string       tag;
    logic [31:0] entry;
    int          count;
    logic [31:0] out_data;
    logic        out_valid;
    logic        drop;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] m_entry;
  int          m_count;
  logic [31:0] m_out_data;
  logic        m_valid;
  logic        m_drop;

  always #5 clk = ~clk;

  keypad_entry_n dut8 (
    .clk       (clk),
    .rst       (rst),
    .pb        (pb),
    .entry     (e8_entry),
    .count     (e8_count),
    .digit_en  (e8_digit_en),
    .full      (e8_full),
    .out_data  (e8_out_data),
    .out_valid (e8_out_valid),
    .out_ready (out_ready),
    .drop      (e8_drop)
  );

  keypad_entry_n #(.DIGITS(4), .RADIX_MAX(9)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .pb        (pb),
    .entry     (e4_entry),
    .count     (e4_count),
    .digit_en  (e4_digit_en),
    .full      (e4_full),
    .out_data  (e4_out_data),
    .out_valid (e4_out_valid),
    .out_ready (out_ready),
    .drop      (e4_drop)
  );

  function automatic logic [19:0] key(input int k);
    return 20'(1) << k;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    m_entry    = '0;
    m_count    = 0;
    m_out_data = '0;
    m_valid    = 1'b0;
    m_drop     = 1'b0;
  endtask

  // Behavioural model of the 8-digit hex instance for one press.
  task automatic modelKey(input logic [19:0] mask, input bit acts);
    int k;
    k = -1;
    if (out_ready) m_valid = 1'b0;
    m_drop = 1'b0;
    if (!acts) return;
    for (int i = 0; i < 20; i++) begin
      if (mask[i]) k = i;
    end
    if (k >= 0 && k <= 15) begin
      if (!(m_count == 0 && k == 0) && m_count != 8) begin
        m_entry = (m_entry << 4) | 32'(k);
        m_count++;
      end
    end else if (k == 16) begin
      if (m_count != 0) begin
        m_entry = m_entry >> 4;
        m_count--;
      end
    end else if (k == 17) begin
      m_entry = '0;
      m_count = 0;
    end else if (k == 19) begin
      if (!m_valid) begin
        m_out_data = m_entry;
        m_valid    = 1'b1;
        m_entry    = '0;
        m_count    = 0;
      end else begin
        m_drop = 1'b1;
      end
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    logic [7:0] de;
    assert_count++;
    assert (sb_q.size() > 0) else begin
      fail_count++;
      $error("[TB] FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = sb_q.pop_front();
    for (int i = 0; i < 8; i++) de[i] = (i < e.count) || (i == 0);
    checkVal({e.tag, " entry"},     e8_entry,             e.entry);
    checkVal({e.tag, " count"},     32'(e8_count),        32'(e.count));
    checkVal({e.tag, " digit_en"},  32'(e8_digit_en),     32'(de));
    checkVal({e.tag, " full"},      32'(e8_full),         32'(e.count == 8));
    checkVal({e.tag, " out_data"},  e8_out_data,          e.out_data);
    checkVal({e.tag, " out_valid"}, 32'(e8_out_valid),    32'(e.out_valid));
    checkVal({e.tag, " drop"},      32'(e8_drop),         32'(e.drop));
  endtask

  // Drive a key pattern right after a falling edge, expect no change before
  // the second rising edge after sampling, then check after it.
  task automatic applyStimulus(input logic [19:0] mask, input string tag,
                               input bit acts, input bit rel);
    exp_t e;
    logic [31:0] prev;
    prev = m_entry;
    pb = mask;
    modelKey(mask, acts);
    e.tag       = tag;
    e.entry     = m_entry;
    e.count     = m_count;
    e.out_data  = m_out_data;
    e.out_valid = m_valid;
    e.drop      = m_drop;
    sb_q.push_back(e);
    repeat (2) @(negedge clk);
    checkVal({tag, " early"}, e8_entry, prev);
    @(negedge clk);
    checkOutput();
    if (rel) begin
      pb = '0;
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    rst       = 1'b0;
    pb        = '0;
    out_ready = 1'b0;
    resetModel();
    repeat (3) @(negedge clk);

    checkVal("reset entry",     e8_entry,           32'h0);
    checkVal("reset count",     32'(e8_count),      32'h0);
    checkVal("reset digit_en",  32'(e8_digit_en),   32'h1);
    checkVal("reset full",      32'(e8_full),       32'h0);
    checkVal("reset out_data",  e8_out_data,        32'h0);
    checkVal("reset out_valid", 32'(e8_out_valid),  32'h0);
    checkVal("reset drop",      32'(e8_drop),       32'h0);
    checkVal("reset d4 digit_en", 32'(e4_digit_en), 32'h1);
    rst = 1'b1;
    @(negedge clk);

    applyStimulus(key(1), "press1", 1, 1);
    applyStimulus(key(2), "press2", 1, 1);
    applyStimulus(key(3), "press3", 1, 1);
    checkVal("hex 123 entry",    e8_entry,         32'h123);
    checkVal("hex 123 digit_en", 32'(e8_digit_en), 32'h07);

    applyStimulus(key(17), "clear", 1, 1);
    applyStimulus(key(0),  "zero a", 1, 1);
    applyStimulus(key(0),  "zero b", 1, 1);
    applyStimulus(key(5),  "five", 1, 1);
    checkVal("five entry", e8_entry, 32'h5);
    applyStimulus(key(16), "bksp a", 1, 1);
    applyStimulus(key(16), "bksp b", 1, 1);

    applyStimulus(key(17), "clear2", 1, 1);
    applyStimulus(key(9),  "d9", 1, 1);
    applyStimulus(key(8),  "d8", 1, 1);
    applyStimulus(key(7),  "d7", 1, 1);
    applyStimulus(key(6),  "d6", 1, 1);
    applyStimulus(key(5),  "d5", 1, 1);
    applyStimulus(key(10), "dA", 1, 1);
    checkVal("dec entry", 32'(e4_entry), 32'h9876);
    checkVal("dec full",  32'(e4_full),  32'h1);
    checkVal("dec count", 32'(e4_count), 32'h4);
    applyStimulus(key(1), "fill1", 1, 1);
    applyStimulus(key(2), "fill2", 1, 1);
    applyStimulus(key(3), "over", 1, 1);
    checkVal("hex full entry", e8_entry,     32'h98765A12);
    checkVal("hex full flag",  32'(e8_full), 32'h1);

    applyStimulus(key(17), "clear3", 1, 1);
    applyStimulus(key(4),  "d4", 1, 1);
    applyStimulus(key(2),  "d2", 1, 1);
    applyStimulus(key(19), "enter42", 1, 1);
    checkVal("enter42 out_data", e8_out_data, 32'h42);
    applyStimulus(key(7),  "d7b", 1, 1);
    applyStimulus(key(19), "enter busy", 1, 0);
    @(negedge clk);
    checkVal("drop one cycle", 32'(e8_drop), 32'h0);
    pb = '0;
    repeat (3) @(negedge clk);

    // out_valid must not react to out_ready before a clock edge.
    out_ready = 1'b1;
    #1;
    checkVal("valid no comb path", 32'(e8_out_valid), 32'h1);
    @(negedge clk);
    checkVal("valid falls", 32'(e8_out_valid), 32'h0);
    m_valid   = 1'b0;
    out_ready = 1'b0;

    applyStimulus(key(19), "enter7", 1, 1);
    applyStimulus(key(9),  "d9b", 1, 1);

    // Enter arrives in the same cycle the pending value is accepted.
    pb = key(19);
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    checkVal("reload valid",    32'(e8_out_valid), 32'h1);
    checkVal("reload out_data", e8_out_data,       32'h9);
    checkVal("reload entry",    e8_entry,          32'h0);
    @(negedge clk);
    checkVal("reload drained", 32'(e8_out_valid), 32'h0);
    out_ready = 1'b0;
    pb = '0;
    repeat (3) @(negedge clk);
    m_entry    = '0;
    m_count    = 0;
    m_out_data = 32'h9;
    m_valid    = 1'b0;

    applyStimulus(key(19), "enter empty", 1, 1);
    out_ready = 1'b1;
    @(negedge clk);
    m_valid   = 1'b0;
    out_ready = 1'b0;

    applyStimulus(key(3), "hold3", 1, 0);
    applyStimulus(key(3) | key(17), "add17", 0, 1);
    applyStimulus(key(3) | key(17), "simul clear", 1, 1);
    applyStimulus(key(4),  "d4b", 1, 1);
    applyStimulus(key(18), "key18", 1, 1);

    applyStimulus(key(5),  "d5b", 1, 1);
    applyStimulus(key(19), "enter45", 1, 1);
    applyStimulus(key(6),  "d6b", 1, 1);
    #2;
    rst = 1'b0;
    #1;
    checkVal("async entry",     e8_entry,          32'h0);
    checkVal("async count",     32'(e8_count),     32'h0);
    checkVal("async digit_en",  32'(e8_digit_en),  32'h1);
    checkVal("async out_data",  e8_out_data,       32'h0);
    checkVal("async out_valid", 32'(e8_out_valid), 32'h0);
    checkVal("async d4 entry",  32'(e4_entry),     32'h0);
    @(negedge clk);
    rst = 1'b1;
    resetModel();
    @(negedge clk);
    applyStimulus(key(2), "after reset", 1, 1);

    checkVal("scoreboard drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/keypad_entry_n.md
# keypad_entry_n

Parametrised keypad number-entry block, successor to the fixed 8-digit hex entry path used by the game top. It synchronises the 20 push-buttons, detects single key presses, and builds a multi-digit number with a configurable radix limit. It supports backspace, clear and enter, and hands the finished value to a consumer over a valid/ready handshake. It sits between `pb[19:0]` and the display/game logic: `entry` drives the seven-segment decoders and `out_data` feeds the game controller.

## Interface
- `DIGITS`, default 8: number of 4-bit digits held; range 1..8; `W = 4*DIGITS`.
- `RADIX_MAX`, default 15: largest accepted digit key; 9 gives decimal entry, 15 gives hex.
- `BKSP_KEY`, default 16: key index for backspace.
- `CLR_KEY`, default 17: key index for clear.
- `ENT_KEY`, default 19: key index for enter.

- `clk`  in  1  system clock (`hz100` at top).
- `rst`  in  1  reset; asynchronous, active-low (0 = reset).
- `pb`  in  20  raw push-buttons, asynchronous to `clk`.
- `entry`  out  W  digits entered so far, right-justified, least-significant digit in `[3:0]`.
- `count`  out  `$clog2(DIGITS+1)`  number of significant digits in `entry`.
- `digit_en`  out  DIGITS  display enables: bit i is 1 when `i < count`; bit 0 is always 1.
- `full`  out  1  `count == DIGITS`.
- `out_data`  out  W  value delivered on enter.
- `out_valid`  out  1  `out_data` is pending.
- `out_ready`  in  1  consumer accepts `out_data`.
- `drop`  out  1  one-cycle pulse: an enter was discarded.

## Operation
- Two-flop synchroniser on all 20 `pb` bits, producing `pbs`. A third register holds `any_d = |pbs` from the previous cycle.
- `press = |pbs & ~any_d`: a rising edge of any-key. Only `press` cycles act. A held key, or a second key added while one is held, produces no action.
- Key code is the highest set index in `pbs`, so simultaneous keys resolve to the highest index. Indices not covered below (e.g. 18) are ignored.
- Digit key k with `k <= RADIX_MAX`:
  - if `count == 0` and `k == 0`: no change (leading zeros are suppressed);
  - else if `full`: ignored;
  - else `entry <= {entry[W-5:0], k}` and `count++`.
- Digit keys above `RADIX_MAX` are ignored.
- `BKSP_KEY`: `entry <= entry >> 4`, `count--`. No change when `count == 0`.
- `CLR_KEY`: `entry <= 0`, `count <= 0`.
- `ENT_KEY`:
  - if `!out_valid` or `out_ready` is high this cycle: `out_data <= entry`, `out_valid <= 1`, then `entry <= 0` and `count <= 0`. An enter with `count == 0` delivers 0.
  - else: entry is kept, `drop` pulses for 1 cycle, and `out_data` is unchanged.
- Handshake: the transfer completes on a cycle with `out_valid & out_ready`. `out_valid` then falls at the next edge, unless an enter loads a new value in that same cycle, in which case `out_valid` stays 1. `out_data` is stable while `out_valid & !out_ready`.
- Reset (asserted at any time, including mid-entry or while a value is pending) clears everything immediately.

## Timing
- Reset values:
  - `entry = 0`, `count = 0`, `full = 0`, `digit_en = 1`;
  - `out_data = 0`, `out_valid = 0`, `drop = 0`;
  - synchroniser and `any_d` registers = 0.
- Latency:
  - `pb` high before edge E0; `pbs` valid after edge E1; `press` is high for the cycle between E1 and E2.
  - `entry`, `count`, `out_valid` and `drop` update at E2.
  - Total latency is 2 edges after first sampling.
- `press` lasts exactly one cycle per any-key rising edge. A release followed by a re-press needs `|pbs` low for at least one cycle.
- `full`, `digit_en` and `count` are registered or derived combinationally from registers only; there is no path from `pb` to any output.
- `out_valid` does not depend combinationally on `out_ready`.

## Test plan
- Reset, then press 1, 2, 3 with `RADIX_MAX = 15`: `entry = 0x123`, `count = 3`, `digit_en = 8'b00000111`. Each press updates 2 cycles after the first sampling edge.
- Press 0, 0, 5, then backspace twice: `entry` goes 0, 0, 0x5, 0, 0 and `count` goes 0, 0, 1, 0, 0. The second backspace causes no underflow.
- With `DIGITS = 4`, `RADIX_MAX = 9`, press 9, 8, 7, 6, 5 and then A: `entry = 0x9876`, `full = 1`. Both the 5 and the A are ignored.
- Enter `0x42` with `out_ready = 0`: `out_valid = 1`, `out_data = 0x42`, `entry = 0`. Enter 7 and press enter again: `drop` pulses and `entry` stays `0x7`. Raise `out_ready`: `out_valid` falls the next cycle.
- Hold key 3 and also press key 17: no second action. Press 3 and 17 simultaneously from idle: clear is executed.
- Assert `rst = 0` mid-entry while `out_valid = 1`: all outputs return to reset values asynchronously, before the next `clk` edge.
